// File: rtl/lsf_histogram_accum.sv
// LSF r-bin histogram accumulator: lazily-cleared bin counts, running maximum,
// and a drain mode that streams every non-empty bin before auto-clearing.
module lsf_histogram_accum #(
  parameter int N_BINS   = 128,
  parameter int BIN_W    = $clog2(N_BINS),
  parameter int CNT_W    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [BIN_W:0]         bin_tdata,
  input  logic                   bin_tvalid,
  output logic                   bin_tready,
  input  logic                   drain_start,
  output logic [BIN_W+CNT_W-1:0] rd_tdata,
  output logic                   rd_tvalid,
  input  logic                   rd_tready,
  output logic                   drain_done,
  output logic [BIN_W-1:0]       max_bin,
  output logic [CNT_W-1:0]       max_count,
  output logic                   max_vld
);
  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic              rdy_q;
  logic [CNT_W-1:0]  mem [N_BINS];
  logic [N_BINS-1:0] vflag;

  // one registered read port, shared by the hit path (ACCUM) and the drain scan
  logic [BIN_W-1:0]  rd_addr;
  logic [CNT_W-1:0]  rdq_cnt;
  logic              rdq_flag;

  logic [2:1]        vld_pipe;
  logic [BIN_W-1:0]  s1_bin, s2_bin;
  logic [CNT_W-1:0]  s2_cnt, s1_new, base_cnt;
  logic              s0_hit, fwd, base_flag, wr_en;

  logic [BIN_W-1:0]  scan_idx, p1_bin;
  logic              scan_act, p1_v, out_hold, drain_end;

  assign bin_tready = enable && rdy_q;
  assign s0_hit     = bin_tvalid && bin_tready && !bin_tdata[BIN_W];
  assign rd_addr    = (state == DRAIN) ? scan_idx : bin_tdata[BIN_W-1:0];
  assign out_hold   = rd_tvalid && !rd_tready;
  assign drain_end  = (state == DRAIN) && !scan_act && !p1_v && (!rd_tvalid || rd_tready);
  assign wr_en      = enable && vld_pipe[1] && !clear;

  // The S1 read raced the write of the hit now in S2; take its value instead.
  assign fwd = vld_pipe[2] && (s2_bin == s1_bin);

  always_comb begin
    base_cnt  = fwd ? s2_cnt : rdq_cnt;
    base_flag = fwd || rdq_flag;
    if (!base_flag)
      s1_new = CNT_W'(1);
    else if (SATURATE && base_cnt == CNT_MAX)
      s1_new = base_cnt;
    else
      s1_new = base_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[s1_bin] <= s1_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vflag <= '0;
    else if (enable) begin
      if (clear || drain_end) vflag <= '0;
      else if (vld_pipe[1])   vflag[s1_bin] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      rdy_q      <= 1'b0;
      vld_pipe   <= '0;
      s1_bin     <= '0;
      s2_bin     <= '0;
      s2_cnt     <= '0;
      rdq_cnt    <= '0;
      rdq_flag   <= 1'b0;
      scan_idx   <= '0;
      scan_act   <= 1'b0;
      p1_v       <= 1'b0;
      p1_bin     <= '0;
      rd_tvalid  <= 1'b0;
      rd_tdata   <= '0;
      drain_done <= 1'b0;
      max_bin    <= '0;
      max_count  <= '0;
      max_vld    <= 1'b0;
    end else if (enable) begin
      vld_pipe[1] <= s0_hit;
      vld_pipe[2] <= vld_pipe[1] && !clear;
      s1_bin      <= bin_tdata[BIN_W-1:0];
      s2_bin      <= s1_bin;
      s2_cnt      <= s1_new;
      if (state != DRAIN || !out_hold) begin
        rdq_cnt  <= mem[rd_addr];
        rdq_flag <= vflag[rd_addr] && !clear;
      end

      max_vld    <= 1'b0;
      drain_done <= 1'b0;
      if (clear || drain_end) begin
        max_bin   <= '0;
        max_count <= '0;
      end else if (vld_pipe[2] && s2_cnt > max_count) begin
        max_bin   <= s2_bin;
        max_count <= s2_cnt;
        max_vld   <= 1'b1;
      end

      case (state)
        ACCUM: begin
          if (drain_start && !clear) begin
            state <= FLUSH;
            rdy_q <= 1'b0;
          end else
            rdy_q <= 1'b1;
        end
        // only S1 still owes a memory write; S2 just updates the max
        FLUSH: begin
          if (clear) begin
            state <= ACCUM;
            rdy_q <= 1'b1;
          end else if (!vld_pipe[1]) begin
            state    <= DRAIN;
            scan_idx <= '0;
            scan_act <= 1'b1;
            p1_v     <= 1'b0;
          end
        end
        DRAIN: begin
          if (clear || drain_end) begin
            state      <= ACCUM;
            rdy_q      <= 1'b1;
            scan_act   <= 1'b0;
            p1_v       <= 1'b0;
            rd_tvalid  <= 1'b0;
            drain_done <= drain_end && !clear;
          end else if (!out_hold) begin
            p1_v      <= scan_act;
            p1_bin    <= scan_idx;
            rd_tvalid <= p1_v && rdq_flag;
            rd_tdata  <= {p1_bin, rdq_cnt};
            if (scan_act) begin
              scan_idx <= scan_idx + 1'b1;
              if (scan_idx == BIN_W'(N_BINS - 1)) scan_act <= 1'b0;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_lsf_histogram_accum.sv
// Drives a saturating and a wrapping lsf_histogram_accum in lockstep and checks
// both every cycle against a bin-level histogram model.
module tb_lsf_histogram_accum;
  localparam int NB = 128;
  localparam int BW = $clog2(NB);
  localparam int CW = 4;
  localparam int DW = BW + CW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, clear = 1'b0;
  logic bin_tvalid = 1'b0, drain_start = 1'b0, rd_tready = 1'b1;
  logic [BW:0] bin_tdata = '0;
  logic          tready [2], rvalid [2], ddone [2], mvld [2];
  logic [DW-1:0] rdata [2];
  logic [BW-1:0] mbin [2];
  logic [CW-1:0] mcnt [2];

  always #5 clk = ~clk;

  lsf_histogram_accum #(.N_BINS(NB), .CNT_W(CW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .bin_tdata(bin_tdata), .bin_tvalid(bin_tvalid), .bin_tready(tready[0]),
    .drain_start(drain_start), .rd_tdata(rdata[0]), .rd_tvalid(rvalid[0]),
    .rd_tready(rd_tready), .drain_done(ddone[0]), .max_bin(mbin[0]),
    .max_count(mcnt[0]), .max_vld(mvld[0]));

  lsf_histogram_accum #(.N_BINS(NB), .CNT_W(CW), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .bin_tdata(bin_tdata), .bin_tvalid(bin_tvalid), .bin_tready(tready[1]),
    .drain_start(drain_start), .rd_tdata(rdata[1]), .rd_tvalid(rvalid[1]),
    .rd_tready(rd_tready), .drain_done(ddone[1]), .max_bin(mbin[1]),
    .max_count(mcnt[1]), .max_vld(mvld[1]));

  typedef struct {int b; int c; bit p;} mx_t;
  typedef struct {logic [DW-1:0] d0; logic [DW-1:0] d1;} beat_t;

  int    total = 0, bad = 0;
  int    cnt_m [2][NB];
  bit    vld_m [NB];
  mx_t   lg [2], dl0 [2], dl1 [2], ex [2];
  bit    busy = 0, rdy_m = 0;
  int    busy_cyc = 0;
  int    pulses [2];
  beat_t exq [$];
  beat_t beats [$];

  function automatic logic [DW-1:0] mk(input int b, input int c);
    mk = {BW'(b), CW'(c)};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wipe();
    for (int b = 0; b < NB; b++) begin
      vld_m[b] = 0;
      cnt_m[0][b] = 0;
      cnt_m[1][b] = 0;
    end
    for (int k = 0; k < 2; k++) lg[k] = '{default: 0};
  endtask

  // apply this cycle's inputs; effects show from the next cycle on
  task automatic step_model();
    bit acc;
    int b, nv;
    acc = bin_tvalid && rdy_m && !bin_tdata[BW];
    b   = int'(bin_tdata[BW-1:0]);
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        ex[k]  = '{default: 0};
        dl1[k] = '{default: 0};
      end else begin
        ex[k]  = dl1[k];
        dl1[k] = dl0[k];
      end
    end
    if (clear) wipe();
    for (int k = 0; k < 2; k++) begin
      lg[k].p = 0;
      if (acc) begin
        if (!vld_m[b])                        nv = 1;
        else if (k == 0 && cnt_m[k][b] == CMAX) nv = CMAX;
        else                                   nv = (cnt_m[k][b] + 1) % (CMAX + 1);
        cnt_m[k][b] = nv;
        if (nv > lg[k].c) lg[k] = '{b, nv, 1'b1};
      end
      dl0[k] = lg[k];
    end
    if (acc) vld_m[b] = 1;
    if (clear) begin
      busy = 0;
      exq.delete();
      rdy_m = 1;
    end else if (drain_start && !busy) begin
      busy = 1;
      busy_cyc = 0;
      rdy_m = 0;
      for (int i = 0; i < NB; i++)
        if (vld_m[i]) exq.push_back('{mk(i, cnt_m[0][i]), mk(i, cnt_m[1][i])});
    end else if (!busy)
      rdy_m = 1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rst_tready%0d", k), tready[k], 0);
        chk($sformatf("rst_rvalid%0d", k), rvalid[k], 0);
        chk($sformatf("rst_rdata%0d", k), rdata[k], 0);
        chk($sformatf("rst_done%0d", k), ddone[k], 0);
        chk($sformatf("rst_maxbin%0d", k), mbin[k], 0);
        chk($sformatf("rst_maxcnt%0d", k), mcnt[k], 0);
        chk($sformatf("rst_maxvld%0d", k), mvld[k], 0);
        ex[k] = '{default: 0}; dl0[k] = '{default: 0}; dl1[k] = '{default: 0};
      end
      wipe();
      busy = 0; rdy_m = 0;
      exq.delete();
    end else begin
      if (ddone[0] || ddone[1]) begin
        chk("done_pair", {ddone[0], ddone[1]}, 2'b11);
        chk("done_while_draining", busy, 1);
        chk("beats_left_at_done", exq.size(), 0);
        busy = 0; rdy_m = 1;
        exq.delete();
        wipe();
        for (int k = 0; k < 2; k++) begin
          ex[k] = '{default: 0}; dl0[k] = '{default: 0}; dl1[k] = '{default: 0};
        end
      end else if (busy) begin
        busy_cyc++;
        if (busy_cyc > NB + 100) begin
          chk("drain_timeout", busy_cyc, NB + 100);
          busy = 0; rdy_m = 1;
          exq.delete();
        end
      end
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tready%0d", k), tready[k], enable && rdy_m);
        chk($sformatf("max_bin%0d", k), mbin[k], ex[k].b);
        chk($sformatf("max_count%0d", k), mcnt[k], ex[k].c);
        chk($sformatf("max_vld%0d", k), mvld[k], ex[k].p);
        if (!busy) chk($sformatf("idle_rvalid%0d", k), rvalid[k], 0);
        pulses[k] += int'(mvld[k]);
      end
      if (busy && (rvalid[0] || rvalid[1])) begin
        if (exq.size() == 0)
          chk("extra_beat", 1, 0);
        else begin
          chk("rvalid0", rvalid[0], 1);
          chk("rvalid1", rvalid[1], 1);
          chk("rdata0", rdata[0], exq[0].d0);
          chk("rdata1", rdata[1], exq[0].d1);
          if (rd_tready) begin
            beats.push_back('{rdata[0], rdata[1]});
            void'(exq.pop_front());
          end
        end
      end
      if (enable) step_model();
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic hit(input int b, input bit x = 1'b0);
    bin_tvalid = 1'b1;
    bin_tdata  = {x, BW'(b)};
    tick();
    bin_tvalid = 1'b0;
    bin_tdata  = '0;
  endtask

  task automatic do_drain(input bit tog);
    beats.delete();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    for (int i = 0; i < NB + 200 && busy; i++) begin
      if (tog) rd_tready = ~rd_tready;
      tick();
    end
    rd_tready = 1'b1;
    tick();
  endtask

  initial begin
    int p0, p1;
    pulses[0] = 0; pulses[1] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // back-to-back same bin, then a different bin below the max
    p0 = pulses[0];
    hit(5); hit(5); hit(5); hit(5); hit(9);
    idle(4);
    chk("t1_pulses", pulses[0] - p0, 4);
    chk("t1_maxbin", mbin[0], 5);
    chk("t1_maxcnt", mcnt[0], 4);
    do_drain(0);
    chk("t1_nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      chk("t1_beat0", beats[0].d0, mk(5, 4));
      chk("t1_beat1", beats[1].d0, mk(9, 1));
    end

    // one-gap repeats with flagged hits in the gaps
    p0 = pulses[0];
    hit(3); hit(3, 1'b1); hit(3); hit(3, 1'b1); hit(3);
    idle(4);
    chk("t2_pulses", pulses[0] - p0, 3);
    chk("t2_maxcnt", mcnt[0], 3);
    do_drain(0);
    chk("t2_nbeats", beats.size(), 1);
    if (beats.size() == 1) chk("t2_beat", beats[0].d0, mk(3, 3));

    // saturate vs wrap
    p0 = pulses[0]; p1 = pulses[1];
    repeat (20) hit(7);
    idle(4);
    chk("t3_max_sat", mcnt[0], 15);
    chk("t3_max_wrap", mcnt[1], 15);
    chk("t3_pulses_wrap", pulses[1] - p1, 15);
    do_drain(0);
    chk("t3_nbeats", beats.size(), 1);
    if (beats.size() == 1) begin
      chk("t3_sat", beats[0].d0, mk(7, 15));
      chk("t3_wrap", beats[0].d1, mk(7, 4));
    end

    // explicit clear between events
    hit(2); hit(2); hit(10);
    idle(4);
    chk("t4_maxbin_a", mbin[0], 2);
    chk("t4_maxcnt_a", mcnt[0], 2);
    clear = 1'b1; tick(); clear = 1'b0;
    hit(10);
    idle(4);
    chk("t4_maxbin_b", mbin[0], 10);
    chk("t4_maxcnt_b", mcnt[0], 1);
    do_drain(0);
    chk("t4_nbeats", beats.size(), 1);
    if (beats.size() == 1) chk("t4_beat", beats[0].d0, mk(10, 1));

    // hit in flight squashed; hit with clear counts in new event
    hit(4);
    clear = 1'b1; hit(6); clear = 1'b0;
    hit(6);
    idle(4);
    do_drain(0);
    chk("t5_nbeats", beats.size(), 1);
    if (beats.size() == 1) chk("t5_beat", beats[0].d0, mk(6, 2));

    // edge bins under toggling backpressure, then an empty drain
    hit(0); hit(NB - 1); hit(NB - 1);
    idle(4);
    do_drain(1);
    chk("t6_nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      chk("t6_beat0", beats[0].d0, mk(0, 1));
      chk("t6_beat1", beats[1].d0, mk(NB - 1, 2));
    end
    do_drain(0);
    chk("t6_empty_nbeats", beats.size(), 0);

    // asynchronous reset in the middle of a drain
    hit(1); hit(1);
    idle(4);
    drain_start = 1'b1; tick(); drain_start = 1'b0;
    idle(20);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_rvalid", rvalid[0], 0);
    chk("t7_async_tready", tready[0], 0);
    chk("t7_async_maxcnt", mcnt[0], 0);
    @(posedge clk); #3 rst_n = 1'b1;
    idle(2);
    hit(1);
    idle(4);
    chk("t7_maxbin", mbin[0], 1);
    chk("t7_maxcnt", mcnt[0], 1);
    do_drain(0);
    chk("t7_nbeats", beats.size(), 1);
    if (beats.size() == 1) chk("t7_beat", beats[0].d0, mk(1, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
